// File: rtl/logic32_result_stage.sv
// Registered AND/OR/XOR/NOT result stage with zero/neg flags and a 2-entry skid buffer; 1-cycle latency.
// InReady depends only on skid occupancy, so OutReady back-pressure never reaches upstream combinationally.
module logic32_result_stage #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   input  logic [1:0]       Op,
   input  logic             InValid,
   output logic             InReady,
   output logic [WIDTH-1:0] Out,
   output logic             Zero,
   output logic             Neg,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [CNT_W-1:0] DoneCnt
);

   typedef struct packed {
      logic [WIDTH-1:0] dat;
      logic             zero;
      logic             neg;
   } entry_t;

   entry_t           main_q, main_d, skid_q, skid_d, new_e;
   logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] res;
   logic             accept, take;

   assign accept = InValid && !skid_vld_q;
   assign take   = main_vld_q && OutReady;

   // NOT never looks at In2, so unknown In2 cannot leak into the result.
   always_comb begin
      res = '0;
      case (Op)
         2'b00:   res = In1 & In2;
         2'b01:   res = In1 | In2;
         2'b10:   res = In1 ^ In2;
         default: res = ~In1;
      endcase
      new_e.dat  = res;
      new_e.zero = (res == '0);
      new_e.neg  = res[WIDTH-1];
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, take};
      case ({main_vld_q, skid_vld_q})
         2'b00: begin
            if (accept) begin
               main_d     = new_e;
               main_vld_d = 1'b1;
            end
         end
         2'b10: begin
            if (accept && take) begin
               main_d = new_e;
            end else if (accept) begin
               skid_d     = new_e;
               skid_vld_d = 1'b1;
            end else if (take) begin
               main_vld_d = 1'b0;
            end
         end
         2'b11: begin
            if (take) begin
               main_d     = skid_q;
               skid_vld_d = 1'b0;
            end
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      InReady  = !skid_vld_q;
      OutValid = main_vld_q;
      Out      = main_q.dat;
      Zero     = main_q.zero;
      Neg      = main_q.neg;
      DoneCnt  = cnt_q;
   end

endmodule

// File: tb/tb_logic32_result_stage.sv
// Directed bench for logic32_result_stage: opcodes, back-pressure, streaming, counter wrap, mid-stream reset.
module tb_logic32_result_stage;

   logic        Clk, Rst, InValid, InReady, OutValid, OutReady, Zero, Neg;
   logic [31:0] In1, In2, Out;
   logic [1:0]  Op;
   logic [15:0] DoneCnt;

   logic        rst4, vld4, rdy4, InReady4, OutValid4, Zero4, Neg4;
   logic [31:0] Out4;
   logic [3:0]  DoneCnt4;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   logic32_result_stage #(.WIDTH(32), .CNT_W(16)) u_dut (
      .Clk(Clk), .Rst(Rst), .In1(In1), .In2(In2), .Op(Op),
      .InValid(InValid), .InReady(InReady), .Out(Out), .Zero(Zero), .Neg(Neg),
      .OutValid(OutValid), .OutReady(OutReady), .DoneCnt(DoneCnt)
   );

   logic32_result_stage #(.WIDTH(32), .CNT_W(4)) u_dut4 (
      .Clk(Clk), .Rst(rst4), .In1(In1), .In2(In2), .Op(Op),
      .InValid(vld4), .InReady(InReady4), .Out(Out4), .Zero(Zero4), .Neg(Neg4),
      .OutValid(OutValid4), .OutReady(rdy4), .DoneCnt(DoneCnt4)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~a;
      endcase
   endfunction

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic cycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic reset_dut();
      Rst      = 1'b1;
      InValid  = 1'b0;
      OutReady = 1'b0;
      repeat (3) cycle();
      Rst = 1'b0;
   endtask

   task automatic test_reset();
      reset_dut();
      chk_cnt++; if (OutValid !== 1'b0) $display("FAIL reset_outvalid got %b exp 0", OutValid); else pass_cnt++;
      chk_cnt++; if (Out !== 32'h0) $display("FAIL reset_out got %h exp 0", Out); else pass_cnt++;
      chk_cnt++; if (Zero !== 1'b0) $display("FAIL reset_zero got %b exp 0", Zero); else pass_cnt++;
      chk_cnt++; if (Neg !== 1'b0) $display("FAIL reset_neg got %b exp 0", Neg); else pass_cnt++;
      chk_cnt++; if (DoneCnt !== 16'd0) $display("FAIL reset_donecnt got %0d exp 0", DoneCnt); else pass_cnt++;
      chk_cnt++; if (InReady !== 1'b1) $display("FAIL reset_inready got %b exp 1", InReady); else pass_cnt++;
      for (int i = 0; i < 10; i++) begin
         OutReady = i[0];
         cycle();
         chk_cnt++;
         if (OutValid !== 1'b0 || DoneCnt !== 16'd0 || InReady !== 1'b1)
            $display("FAIL idle_hold cyc %0d got vld %b cnt %0d rdy %b exp 0 0 1", i, OutValid, DoneCnt, InReady);
         else pass_cnt++;
      end
   endtask

   task automatic test_opcodes();
      logic [31:0] va[6], vb[6], ve[6];
      logic [1:0]  vo[6];
      logic        vz[6], vn[6];
      va = '{32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hFFFF_FFFF, 32'h1234_5678};
      vb = '{32'h0FF0_FFFF, 32'h0FF0_FFFF, 32'h0FF0_FFFF, 32'h0FF0_FFFF, 32'h0FF0_FFFF, 32'hxxxx_xxxx};
      vo = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11};
      ve = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB, 32'h0F0F_EDCB, 32'h0000_0000, 32'hEDCB_A987};
      vz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vn = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      reset_dut();
      OutReady = 1'b1;
      for (int i = 0; i < 6; i++) begin
         In1 = va[i]; In2 = vb[i]; Op = vo[i]; InValid = 1'b1;
         cycle();
         InValid = 1'b0;
         chk_cnt++;
         if (OutValid !== 1'b1 || Out !== ve[i] || Zero !== vz[i] || Neg !== vn[i])
            $display("FAIL opcode_%0d got vld %b out %h z %b n %b exp 1 %h %b %b",
                     i, OutValid, Out, Zero, Neg, ve[i], vz[i], vn[i]);
         else pass_cnt++;
         cycle();
      end
      chk_cnt++; if (DoneCnt !== 16'd6) $display("FAIL opcode_donecnt got %0d exp 6", DoneCnt); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] got[$];
      logic        acc;
      reset_dut();
      Op = 2'b01; In2 = 32'h0;
      In1 = 32'h1; InValid = 1'b1;
      cycle();
      In1 = 32'h2;
      cycle();
      chk_cnt++; if (InReady !== 1'b0) $display("FAIL bp_full_inready got %b exp 0", InReady); else pass_cnt++;
      In1 = 32'hC3;
      cycle();
      chk_cnt++;
      if (InReady !== 1'b0 || OutValid !== 1'b1 || Out !== 32'h1)
         $display("FAIL bp_hold got rdy %b vld %b out %h exp 0 1 00000001", InReady, OutValid, Out);
      else pass_cnt++;
      OutReady = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (OutValid && OutReady) got.push_back(Out);
         acc = InValid && InReady;
         cycle();
         if (acc) InValid = 1'b0;
      end
      chk_cnt++; if (got.size() !== 3) $display("FAIL bp_count got %0d exp 3", got.size()); else pass_cnt++;
      if (got.size() == 3) begin
         chk_cnt++;
         if (got[0] !== 32'h1 || got[1] !== 32'h2 || got[2] !== 32'hC3)
            $display("FAIL bp_order got %h %h %h exp 00000001 00000002 000000c3", got[0], got[1], got[2]);
         else pass_cnt++;
      end
      chk_cnt++; if (DoneCnt !== 16'd3) $display("FAIL bp_donecnt got %0d exp 3", DoneCnt); else pass_cnt++;
   endtask

   task automatic test_streaming();
      logic [31:0] exp_q[$];
      logic [31:0] e, held;
      logic        acc, tk, hold;
      int          sent, rcvd;
      reset_dut();
      sent = 0; rcvd = 0;
      In1 = $urandom(); In2 = $urandom(); Op = 2'($urandom_range(0, 3)); InValid = 1'b1;
      OutReady = 1'($urandom_range(0, 1));
      for (int c = 0; c < 3000 && rcvd < 100; c++) begin
         acc  = InValid && InReady;
         tk   = OutValid && OutReady;
         hold = OutValid && !OutReady;
         held = Out;
         if (tk) begin
            rcvd++;
            chk_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL stream_extra got %h exp nothing", Out);
            end else begin
               e = exp_q.pop_front();
               if (Out !== e || Zero !== (e == 32'h0) || Neg !== e[31])
                  $display("FAIL stream_word %0d got %h z %b n %b exp %h", rcvd, Out, Zero, Neg, e);
               else pass_cnt++;
            end
         end
         if (acc) begin
            exp_q.push_back(model(In1, In2, Op));
            sent++;
         end
         cycle();
         if (hold) begin
            chk_cnt++;
            if (OutValid !== 1'b1 || Out !== held)
               $display("FAIL stream_stable got vld %b out %h exp 1 %h", OutValid, Out, held);
            else pass_cnt++;
         end
         if (acc) begin
            if (sent < 100) begin
               In1 = $urandom(); In2 = $urandom(); Op = 2'($urandom_range(0, 3));
            end else InValid = 1'b0;
         end
         OutReady = 1'($urandom_range(0, 1));
      end
      InValid = 1'b0;
      chk_cnt++; if (rcvd !== 100) $display("FAIL stream_count got %0d exp 100", rcvd); else pass_cnt++;
      chk_cnt++; if (DoneCnt !== 16'd100) $display("FAIL stream_donecnt got %0d exp 100", DoneCnt); else pass_cnt++;
   endtask

   task automatic test_counter_wrap();
      int   takes, sent;
      logic tk;
      rst4 = 1'b1; vld4 = 1'b0; rdy4 = 1'b1;
      In1 = 32'h5; In2 = 32'h3; Op = 2'b10;
      repeat (2) cycle();
      rst4 = 1'b0;
      takes = 0; sent = 0;
      vld4 = 1'b1;
      for (int c = 0; c < 40; c++) begin
         tk = OutValid4 && rdy4;
         if (tk) takes++;
         if (vld4 && InReady4) sent++;
         cycle();
         if (sent == 17) vld4 = 1'b0;
         if (tk && takes == 15) begin
            chk_cnt++; if (DoneCnt4 !== 4'd15) $display("FAIL wrap_15 got %0d exp 15", DoneCnt4); else pass_cnt++;
         end
         if (tk && takes == 16) begin
            chk_cnt++; if (DoneCnt4 !== 4'd0) $display("FAIL wrap_16 got %0d exp 0", DoneCnt4); else pass_cnt++;
         end
         if (tk && takes == 17) begin
            chk_cnt++; if (DoneCnt4 !== 4'd1) $display("FAIL wrap_17 got %0d exp 1", DoneCnt4); else pass_cnt++;
         end
      end
      chk_cnt++; if (takes !== 17) $display("FAIL wrap_takes got %0d exp 17", takes); else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      reset_dut();
      Op = 2'b01; In2 = 32'h0;
      In1 = 32'h0000_AAAA; InValid = 1'b1;
      cycle();
      In1 = 32'h0000_BBBB;
      cycle();
      InValid = 1'b0;
      chk_cnt++; if (InReady !== 1'b0) $display("FAIL midrst_full got %b exp 0", InReady); else pass_cnt++;
      Rst = 1'b1;
      cycle();
      Rst = 1'b0;
      chk_cnt++; if (OutValid !== 1'b0) $display("FAIL midrst_outvalid got %b exp 0", OutValid); else pass_cnt++;
      chk_cnt++; if (DoneCnt !== 16'd0) $display("FAIL midrst_donecnt got %0d exp 0", DoneCnt); else pass_cnt++;
      chk_cnt++; if (InReady !== 1'b1) $display("FAIL midrst_inready got %b exp 1", InReady); else pass_cnt++;
      OutReady = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk_cnt++;
         if (OutValid !== 1'b0 || Out !== 32'h0)
            $display("FAIL midrst_stale cyc %0d got vld %b out %h exp 0 00000000", i, OutValid, Out);
         else pass_cnt++;
      end
   endtask

   initial begin
      Rst = 1'b1; InValid = 1'b0; OutReady = 1'b0;
      In1 = '0; In2 = '0; Op = '0;
      rst4 = 1'b1; vld4 = 1'b0; rdy4 = 1'b0;
      test_reset();
      test_opcodes();
      test_back_to_back();
      test_streaming();
      test_counter_wrap();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/logic32_result_stage.md
Name: logic32_result_stage

Overview:
Registered output stage for the 32-bit logic unit. It accepts operands and a logic opcode (AND/OR/XOR/NOT) over a valid/ready handshake and computes the result. The result is held with zero and negative flags in a 2-entry skid buffer so back-pressure from the ALU32 writeback path never drops or duplicates a result. It also counts completed output transfers.

Parameters:
WIDTH, 32, operand/result width in bits; flags are derived from bit WIDTH-1 and the full word.
CNT_W, 16, width of the completed-transfer counter.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Rst  input  1  synchronous, active-high reset.
In1  input  WIDTH  operand A.
In2  input  WIDTH  operand B; ignored for NOT.
Op  input  2  opcode: 00 AND, 01 OR, 10 XOR, 11 NOT (~In1).
InValid  input  1  upstream offers In1/In2/Op this cycle.
InReady  output  1  stage can accept this cycle.
Out  output  WIDTH  registered result.
Zero  output  1  Out == 0.
Neg  output  1  Out[WIDTH-1].
OutValid  output  1  Out/Zero/Neg hold a valid result.
OutReady  input  1  downstream consumes when OutValid && OutReady.
DoneCnt  output  CNT_W  number of completed output transfers, wrapping.

Behaviour:
- One clock (Clk). Rst is synchronous and active-high. Sampled only at the rising edge of Clk, Rst overrides every other input that cycle.
- Reset values: OutValid=0, Out=0, Zero=0, Neg=0, DoneCnt=0, skid empty.
- InReady = ~skid_valid (registered state only, with no combinational path from OutReady). InReady reads 1 in the first cycle after Rst is released.
- Accept = InValid && InReady. Take = OutValid && OutReady.
- The result is computed combinationally from In1/In2/Op at accept and stored together with its flags. Zero and Neg are stored with the data, not recomputed from Out.
- Latency: a word accepted in cycle N appears on Out with OutValid=1 in cycle N+1. Throughput is 1 word/cycle while OutReady=1.
- States, derived from main_valid and skid_valid:
  - EMPTY (0,0): Accept -> load main -> ONE.
  - ONE (1,0):
    - Accept & Take -> reload main -> ONE.
    - Accept & !Take -> load skid -> FULL.
    - !Accept & Take -> EMPTY.
    - otherwise hold.
  - FULL (1,1): InReady=0. Take -> skid moves to main, skid clears -> ONE. No Take -> hold.
- Outputs are stable while OutValid=1 && OutReady=0: Out, Zero and Neg do not change until Take.
- Ordering is strictly FIFO. The skid entry is never presented before the main entry.
- DoneCnt increments by 1 on every Take and wraps from 2^CNT_W-1 to 0.
- Opcode 11 ignores In2 entirely. An X or any value on In2 must not affect Out.
- InValid with InReady=0: no state change. Upstream must hold its data; the stage does not latch it.
- OutReady toggling while OutValid=0 has no effect.
- Rst asserted mid-stream (any state) discards both entries and clears DoneCnt in the same edge. OutValid=0 the next cycle, and no stale data is presented after reset.

Test Plan:
- Reset/idle: hold Rst 3 cycles, release -> OutValid=0, Out=0, Zero=0, Neg=0, DoneCnt=0, InReady=1. With no InValid, state stays unchanged for 10 cycles.
- Opcode sweep with OutReady=1: In1=0xF0F0_1234, In2=0x0FF0_FFFF.
  - AND -> Out=0x00F0_1234, Zero=0, Neg=0, one cycle after accept.
  - OR -> 0xFFF0_FFFF, Neg=1.
  - XOR -> 0xFF00_EDCB, Neg=1.
  - NOT -> 0x0F0F_EDCB, Neg=0.
  - NOT with In1=0xFFFF_FFFF -> Out=0, Zero=1.
- Back-pressure: OutReady=0, send A=0x1, B=0x2 (OR with In2=0) -> both accepted, InReady=0 from the cycle after B. Offer C: not accepted. Raise OutReady -> Out sequence 0x1, 0x2, C, with no loss or duplication and DoneCnt=3.
- Streaming: 100 random words, OutReady random at 50% -> scoreboard match in order. DoneCnt=100. Out stays stable whenever OutValid && !OutReady.
- Counter wrap: CNT_W=4, 17 transfers -> DoneCnt reads 15 after 15 transfers, 0 after 16, 1 after 17.
- Reset mid-operation: enter FULL with two pending words, assert Rst for 1 cycle -> next cycle OutValid=0, DoneCnt=0, InReady=1. Neither pending word ever appears on Out.
